// File: rtl/canny_vip_packetizer.sv
// Canny output packetizer: pulls grayscale pixels from an FWFT FIFO and emits
// one VIP control packet followed by a WIDTH*HEIGHT beat video frame.
module canny_vip_packetizer #(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3,
    parameter int WIDTH            = 1280,
    parameter int HEIGHT           = 720
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         fifo_empty,
    output logic                                         fifo_rd_en,
    input  logic [BITS_PER_SYMBOL-1:0]                   fifo_dout,
    input  logic                                         stall_out,
    output logic                                         write,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0]  data_out,
    output logic                                         end_of_video_out,
    output logic [15:0]                                  width_out,
    output logic [15:0]                                  height_out,
    output logic [3:0]                                   interlaced_out,
    input  logic                                         vip_ctrl_busy,
    output logic                                         vip_ctrl_send,
    output logic                                         frame_done
);

    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int IW    = $clog2(TOTAL + 1);
    localparam int XW    = $clog2(WIDTH + 1);
    localparam int YW    = $clog2(HEIGHT + 1);

    localparam logic [IW-1:0] ISSUE_END  = IW'(TOTAL);
    localparam logic [IW-1:0] ISSUE_LAST = IW'(TOTAL - 1);
    localparam logic [XW-1:0] X_LAST     = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(HEIGHT - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CTRL   = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;

    logic [1:0]                 state;
    logic [1:0]                 count;
    logic [BITS_PER_SYMBOL-1:0] pix0, pix1;
    logic                       last0, last1;
    logic [IW-1:0]              issued;
    logic [XW-1:0]              x;
    logic [YW-1:0]              y;
    logic                       push, pop, push_last;

    // Read decision depends only on registered state, never on stall_out.
    assign push       = rst_n && (state == STREAM) && !fifo_empty
                        && (count != 2'd2) && (issued < ISSUE_END);
    assign push_last  = (issued == ISSUE_LAST);
    assign fifo_rd_en = push;

    assign write            = (state == STREAM) && (count != 2'd0);
    assign pop              = write && !stall_out;
    assign data_out         = {SYMBOLS_PER_BEAT{pix0}};
    assign end_of_video_out = write && last0;

    assign width_out      = 16'(WIDTH);
    assign height_out     = 16'(HEIGHT);
    assign interlaced_out = 4'd0;

    // Skid buffer: entry 0 is always the head; it keeps its pixel once drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix0  <= '0;
            pix1  <= '0;
            last0 <= 1'b0;
            last1 <= 1'b0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        pix0  <= fifo_dout;
                        last0 <= push_last;
                    end else begin
                        pix1  <= fifo_dout;
                        last1 <= push_last;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        pix0  <= pix1;
                        last0 <= last1;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    pix0  <= fifo_dout;
                    last0 <= push_last;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            vip_ctrl_send <= 1'b0;
            frame_done    <= 1'b0;
            issued        <= '0;
            x             <= '0;
            y             <= '0;
        end else begin
            vip_ctrl_send <= 1'b0;
            frame_done    <= 1'b0;
            if (push)
                issued <= issued + 1'b1;
            case (state)
                IDLE: if (!fifo_empty) state <= CTRL;
                CTRL: if (!vip_ctrl_busy) begin
                    vip_ctrl_send <= 1'b1;
                    state         <= STREAM;
                end
                STREAM: if (pop && last0) begin
                    frame_done <= 1'b1;
                    issued     <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (pop) begin
                if (last0) begin
                    assert (x == X_LAST && y == Y_LAST);
                    x <= '0;
                    y <= '0;
                end else if (x == X_LAST) begin
                    x <= '0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_canny_vip_packetizer.sv
// Directed bench for canny_vip_packetizer on a 4x2 frame with a queue-based FWFT FIFO model.
module tb_canny_vip_packetizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_dout;
    logic        stall_out;
    logic        write;
    logic [23:0] data_out;
    logic        end_of_video_out;
    logic [15:0] width_out, height_out;
    logic [3:0]  interlaced_out;
    logic        vip_ctrl_busy;
    logic        vip_ctrl_send;
    logic        frame_done;

    canny_vip_packetizer #(
        .BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3), .WIDTH(4), .HEIGHT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .stall_out(stall_out), .write(write), .data_out(data_out),
        .end_of_video_out(end_of_video_out), .width_out(width_out), .height_out(height_out),
        .interlaced_out(interlaced_out), .vip_ctrl_busy(vip_ctrl_busy),
        .vip_ctrl_send(vip_ctrl_send), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  q[$];
    bit          hide = 1'b0;
    bit          toggle = 1'b0;
    int          cyc_n = 0;
    int          n_send, n_done, n_pop, send_cyc, done_cyc;
    logic [23:0] bdat[$];
    logic        beov[$];
    int          bcyc[$];
    logic        s_rd, s_wr, s_eov, s_send, s_done;
    logic [23:0] s_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (q.size() == 0) || hide;
        fifo_dout  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic load(input int first, input int last);
        for (int i = first; i <= last; i++) q.push_back(8'(i));
        drive_fifo();
    endtask

    task automatic clear_logs();
        bdat.delete(); beov.delete(); bcyc.delete();
        n_send = 0; n_done = 0; n_pop = 0; send_cyc = -1; done_cyc = -1;
    endtask

    // Sample on the falling edge, update the FIFO model just after the rising edge.
    task automatic cyc();
        @(negedge clk);
        s_rd = fifo_rd_en; s_wr = write; s_data = data_out; s_eov = end_of_video_out;
        s_send = vip_ctrl_send; s_done = frame_done;
        if (s_wr && !stall_out) begin
            bdat.push_back(s_data); beov.push_back(s_eov); bcyc.push_back(cyc_n);
        end
        if (s_rd) n_pop++;
        if (s_send) begin n_send++; send_cyc = cyc_n; end
        if (s_done) begin n_done++; done_cyc = cyc_n; end
        @(posedge clk);
        #1;
        if (s_rd && q.size() != 0) void'(q.pop_front());
        cyc_n++;
        if (toggle) hide = !hide;
        drive_fifo();
    endtask

    task automatic run_frame(input string tag, input int budget);
        int d0;
        d0 = n_done;
        for (int k = 0; k < budget && n_done == d0; k++) cyc();
        chk({tag, "_done"}, 32'(n_done - d0), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int base);
        logic [7:0] p;
        chk({tag, "_nbeats"}, 32'(bdat.size()), 32'd8);
        for (int i = 0; i < 8 && i < bdat.size(); i++) begin
            p = 8'(base + i);
            chk($sformatf("%s_beat%0d", tag, i), 32'(bdat[i]), 32'({p, p, p}));
            chk($sformatf("%s_eov%0d", tag, i), 32'(beov[i]), 32'(i == 7));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol, held, sp, stall_rem;
        rst_n = 1'b0; stall_out = 1'b0; vip_ctrl_busy = 1'b0;
        drive_fifo();
        clear_logs();

        // Reset values
        repeat (3) cyc();
        chk("rst_rd_en", 32'(s_rd), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("rst_write", 32'(s_wr), 32'd0);
        chk("rst_data", 32'(s_data), 32'd0);
        chk("rst_eov", 32'(s_eov), 32'd0);
        chk("rst_send", 32'(s_send), 32'd0);
        chk("rst_done", 32'(s_done), 32'd0);
        chk("width_out", 32'(width_out), 32'd4);
        chk("height_out", 32'(height_out), 32'd2);
        chk("interlaced_out", 32'(interlaced_out), 32'd0);

        // 1: basic frame
        clear_logs();
        load(1, 8);
        run_frame("t1", 40);
        chk("t1_sends", 32'(n_send), 32'd1);
        check_frame("t1", 1);
        if (bdat.size() == 8) begin
            chk("t1_span", 32'(bcyc[7] - bcyc[0]), 32'd7);
            chk("t1_first_lat", 32'(bcyc[0] - send_cyc), 32'd1);
            chk("t1_done_lat", 32'(done_cyc - bcyc[7]), 32'd1);
        end
        chk("t1_pops", 32'(n_pop), 32'd8);
        repeat (5) cyc();
        chk("t1_idle_sends", 32'(n_send), 32'd1);
        chk("t1_idle_write", 32'(s_wr), 32'd0);

        // 2: five-cycle stall while beat 3 is presented
        clear_logs();
        load(1, 8);
        held = 0; sp = 0; stall_rem = 5;
        for (int k = 0; k < 60 && n_done == 0; k++) begin
            cyc();
            if (stall_out) begin
                if (s_wr && s_data == 24'h030303) held++;
                if (s_rd) sp++;
            end
            if (bdat.size() == 2 && stall_rem > 0) begin
                if (stall_rem == 5 && s_rd) sp++;
                stall_out = 1'b1;
                stall_rem--;
            end else begin
                stall_out = 1'b0;
            end
        end
        stall_out = 1'b0;
        chk("t2_done", 32'(n_done), 32'd1);
        chk("t2_held", 32'(held), 32'd5);
        chk("t2_fill_pops", 32'(sp), 32'd2);
        chk("t2_pops", 32'(n_pop), 32'd8);
        check_frame("t2", 1);

        // 3: encoder busy holds the frame in CTRL
        clear_logs();
        vip_ctrl_busy = 1'b1;
        load(1, 8);
        viol = 0;
        repeat (10) begin
            cyc();
            if (s_send || s_rd || s_wr) viol++;
        end
        chk("t3_busy_quiet", 32'(viol), 32'd0);
        chk("t3_fifo_kept", 32'(q.size()), 32'd8);
        vip_ctrl_busy = 1'b0;
        cyc();
        chk("t3_send_early", 32'(s_send), 32'd0);
        cyc();
        chk("t3_send", 32'(s_send), 32'd1);
        run_frame("t3", 40);
        chk("t3_sends", 32'(n_send), 32'd1);
        check_frame("t3", 1);

        // 4: frame plus four pixels
        clear_logs();
        load(1, 12);
        run_frame("t4a", 40);
        chk("t4_pops", 32'(n_pop), 32'd8);
        chk("t4_left", 32'(q.size()), 32'd4);
        check_frame("t4a", 1);
        clear_logs();
        for (int k = 0; k < 20 && bdat.size() == 0; k++) cyc();
        chk("t4_send2", 32'(n_send), 32'd1);
        chk("t4_first2", 32'(bdat.size() != 0 ? bdat[0] : 24'h0), 32'h090909);
        load(13, 16);
        run_frame("t4b", 40);
        check_frame("t4b", 9);

        // 5: FIFO empty toggling
        clear_logs();
        toggle = 1'b1;
        load(1, 8);
        run_frame("t5", 80);
        toggle = 1'b0; hide = 1'b0; drive_fifo();
        check_frame("t5", 1);
        if (bdat.size() == 8) chk("t5_gaps", 32'((bcyc[7] - bcyc[0]) > 7), 32'd1);

        // 6: reset after beat 5
        clear_logs();
        load(1, 8);
        for (int k = 0; k < 30 && bdat.size() < 5; k++) cyc();
        chk("t6_five", 32'(bdat.size()), 32'd5);
        rst_n = 1'b0;
        cyc();
        chk("t6_rst_rd", 32'(s_rd), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("t6_write", 32'(s_wr), 32'd0);
        chk("t6_data", 32'(s_data), 32'd0);
        chk("t6_eov", 32'(s_eov), 32'd0);
        chk("t6_send", 32'(s_send), 32'd0);
        chk("t6_done", 32'(s_done), 32'd0);
        chk("t6_left", 32'(q.size()), 32'd2);
        clear_logs();
        load(9, 14);
        run_frame("t6", 40);
        chk("t6_sends", 32'(n_send), 32'd1);
        check_frame("t6", 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
